byte_cmd_serializer: RTL



---
 rtl/byte_cmd_serializer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/byte_cmd_serializer.sv
// Small synchronous FIFO with a registered occupancy count. Writes are ignored when full, reads when empty.
// Latency: a write is visible on rd_dat in the cycle after the push edge; rd_dat is combinational from the head entry.
// Backpressure: full is count[MSB], which relies on DEPTH being a power of two; a pop does not free space for a same-cycle push.
module sync_fifo #(
    parameter int WIDTH      = 56,
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wr_dat,
    output logic [WIDTH-1:0]      rd_dat,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = count[DEPTH_LOG2];
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; pointer reset alone discards stale entries.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Serializes address/data write commands into MSB-first byte frames on ID/IValid.
// Latency: push at E0 into an idle block, pop at E1, byte0 registered at E2; queued frames follow with no bubble.
// Backpressure: CmdReady = !full (low during reset); Rdyn=1 at a launch edge holds ID and index with IValid low.
module byte_cmd_serializer #(
    parameter int ADDR_WIDTH      = 24,
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int GAP_CYCLES      = 0
) (
    input  logic                       Clk,
    input  logic                       ARst,
    input  logic [ADDR_WIDTH-1:0]      CmdAddr,
    input  logic [DATA_WIDTH-1:0]      CmdData,
    input  logic                       CmdValid,
    output logic                       CmdReady,
    input  logic                       Rdyn,
    output logic [7:0]                 ID,
    output logic                       IValid,
    output logic                       Busy,
    output logic [FIFO_DEPTH_LOG2:0]   Level
);
    localparam int FRAME_BITS = ADDR_WIDTH + DATA_WIDTH;
    localparam int NBYTES     = FRAME_BITS / 8;
    localparam int IDX_W      = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [3:0]       GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [FRAME_BITS-1:0] frame_sr;
    logic [FRAME_BITS-1:0] frame_sr_nxt;
    logic [IDX_W-1:0]      byte_idx;
    logic [IDX_W-1:0]      byte_idx_nxt;
    logic [3:0]            gap_cnt;
    logic [3:0]            gap_cnt_nxt;
    logic [7:0]            id_nxt;
    logic                  ivalid_nxt;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FRAME_BITS-1:0] fifo_rd_dat;

    assign CmdReady  = ~fifo_full & ~ARst;
    assign fifo_push = CmdValid & CmdReady;
    assign Busy      = (state != IDLE) | (Level != '0);

    sync_fifo #(
        .WIDTH      (FRAME_BITS),
        .DEPTH      (FIFO_DEPTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_cmd_fifo (
        .clk    (Clk),
        .rst    (ARst),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wr_dat ({CmdAddr, CmdData}),
        .rd_dat (fifo_rd_dat),
        .count  (Level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge Clk or posedge ARst) begin
        if (ARst) begin
            state    <= IDLE;
            frame_sr <= '0;
            byte_idx <= '0;
            gap_cnt  <= '0;
            ID       <= '0;
            IValid   <= 1'b0;
        end else begin
            state    <= state_nxt;
            frame_sr <= frame_sr_nxt;
            byte_idx <= byte_idx_nxt;
            gap_cnt  <= gap_cnt_nxt;
            ID       <= id_nxt;
            IValid   <= ivalid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        frame_sr_nxt = frame_sr;
        byte_idx_nxt = byte_idx;
        gap_cnt_nxt  = gap_cnt;
        id_nxt       = ID;
        ivalid_nxt   = 1'b0;
        fifo_pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    frame_sr_nxt = fifo_rd_dat;
                    byte_idx_nxt = '0;
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                // The shift register always presents the next byte at its top.
                if (!Rdyn) begin
                    id_nxt       = frame_sr[FRAME_BITS-1 -: 8];
                    ivalid_nxt   = 1'b1;
                    frame_sr_nxt = frame_sr << 8;
                    byte_idx_nxt = byte_idx + 1'b1;
                    if (byte_idx == LAST_IDX) begin
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_nxt = '0;
                            state_nxt   = GAP;
                        end else if (!fifo_empty) begin
                            fifo_pop     = 1'b1;
                            frame_sr_nxt = fifo_rd_dat;
                            byte_idx_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
